// File: rtl/chunk_storage_pool_n_if.sv
// Signal bundle for chunk_storage_pool_n: core data/fetch ports plus the DDR
// write-back, refill and flush channels.
interface chunk_storage_pool_n_if #(
    parameter int unsigned CHUNK_PART   = 128,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned MASK_SIZE    = DATA_SIZE / 8,
    parameter int unsigned ADDRESS_SIZE = 28
);
    logic [ADDRESS_SIZE-1:0] address;
    logic [MASK_SIZE-1:0]    mask;
    logic                    write_trigger;
    logic [DATA_SIZE-1:0]    write_value;
    logic                    read_trigger;
    logic [DATA_SIZE-1:0]    read_value;
    logic                    contains_address;
    logic [ADDRESS_SIZE-1:0] command_address;
    logic [DATA_SIZE-1:0]    read_command;
    logic                    contains_command_address;
    logic                    busy;
    logic                    save_valid;
    logic                    save_ready;
    logic [ADDRESS_SIZE-1:0] save_address;
    logic [CHUNK_PART-1:0]   save_data;
    logic                    fill_req_valid;
    logic                    fill_req_ready;
    logic [ADDRESS_SIZE-1:0] fill_req_address;
    logic                    fill_data_valid;
    logic [CHUNK_PART-1:0]   fill_data;
    logic                    flush_trigger;
    logic                    flush_done;

    modport slave (
        input  address, mask, write_trigger, write_value, read_trigger, command_address,
               save_ready, fill_req_ready, fill_data_valid, fill_data, flush_trigger,
        output read_value, contains_address, read_command, contains_command_address, busy,
               save_valid, save_address, save_data, fill_req_valid, fill_req_address,
               flush_done
    );

    modport master (
        output address, mask, write_trigger, write_value, read_trigger, command_address,
               save_ready, fill_req_ready, fill_data_valid, fill_data, flush_trigger,
        input  read_value, contains_address, read_command, contains_command_address, busy,
               save_valid, save_address, save_data, fill_req_valid, fill_req_address,
               flush_done
    );
endinterface

// File: rtl/chunk_storage_pool_n.sv
// N-way fully associative chunk cache with LRU replacement, built-in miss
// handling (write-back, refill, install) and an explicit flush walk.
module chunk_storage_pool_n #(
    parameter int unsigned WAYS         = 4,
    parameter int unsigned CHUNK_PART   = 128,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned MASK_SIZE    = DATA_SIZE / 8,
    parameter int unsigned ADDRESS_SIZE = 28
) (
    input logic                   clk,
    input logic                   rst_n,
    chunk_storage_pool_n_if.slave bus
);
    localparam int unsigned WORDS       = CHUNK_PART / DATA_SIZE;
    localparam int unsigned OFFSET_BITS = $clog2(CHUNK_PART / 8);
    localparam int unsigned WORD_BITS   = $clog2(WORDS);
    localparam int unsigned TAG_BITS    = ADDRESS_SIZE - OFFSET_BITS;
    localparam int unsigned WAY_BITS    = $clog2(WAYS);
    localparam int unsigned AGE_BITS    = $clog2(WAYS);
    localparam int unsigned PTR_BITS    = WAY_BITS + 1;
    localparam logic [AGE_BITS-1:0] AGE_MAX  = AGE_BITS'(WAYS - 1);
    localparam logic [PTR_BITS-1:0] PTR_DONE = PTR_BITS'(WAYS);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StReq,
        StWait,
        StFlushScan,
        StFlushWb
    } state_e;

    state_e state_q, state_d;

    logic [CHUNK_PART-1:0] data_q [WAYS];
    logic [TAG_BITS-1:0]   tag_q  [WAYS];
    logic [WAYS-1:0]       valid_q, valid_d;
    logic [WAYS-1:0]       dirty_q, dirty_d;
    logic [AGE_BITS-1:0]   age_q  [WAYS];
    logic [AGE_BITS-1:0]   age_d  [WAYS];

    logic [WAY_BITS-1:0]     victim_q, victim_d;
    logic [PTR_BITS-1:0]     ptr_q, ptr_d;
    logic [ADDRESS_SIZE-1:0] save_address_q, save_address_d;
    logic [CHUNK_PART-1:0]   save_data_q, save_data_d;
    logic [ADDRESS_SIZE-1:0] fill_req_address_q, fill_req_address_d;
    logic                    flush_done_q, flush_done_d;

    function automatic logic [DATA_SIZE-1:0] word_of(input logic [CHUNK_PART-1:0] chunk,
                                                     input logic [WORD_BITS-1:0]  idx);
        word_of = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == WORD_BITS'(w)) word_of = chunk[w*DATA_SIZE +: DATA_SIZE];
        end
    endfunction

    function automatic logic [CHUNK_PART-1:0] merge_word(input logic [CHUNK_PART-1:0] chunk,
                                                         input logic [WORD_BITS-1:0]  idx,
                                                         input logic [MASK_SIZE-1:0]  m,
                                                         input logic [DATA_SIZE-1:0]  v);
        merge_word = chunk;
        for (int w = 0; w < WORDS; w++) begin
            for (int b = 0; b < MASK_SIZE; b++) begin
                if (idx == WORD_BITS'(w) && m[b]) begin
                    merge_word[w*DATA_SIZE+b*8 +: 8] = v[b*8 +: 8];
                end
            end
        end
    endfunction

    // The word select is taken from the address bits just above the chunk offset.
    logic [TAG_BITS-1:0]  data_tag, cmd_tag;
    logic [WORD_BITS-1:0] data_word, cmd_word;
    assign data_tag  = bus.address[ADDRESS_SIZE-1:OFFSET_BITS];
    assign cmd_tag   = bus.command_address[ADDRESS_SIZE-1:OFFSET_BITS];
    assign data_word = bus.address[OFFSET_BITS +: WORD_BITS];
    assign cmd_word  = bus.command_address[OFFSET_BITS +: WORD_BITS];

    logic                data_hit, cmd_hit;
    logic [WAY_BITS-1:0] data_way, cmd_way;

    always_comb begin
        data_hit = 1'b0;
        data_way = '0;
        cmd_hit  = 1'b0;
        cmd_way  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[i] && tag_q[i] == data_tag) begin
                data_hit = 1'b1;
                data_way = WAY_BITS'(i);
            end
            if (valid_q[i] && tag_q[i] == cmd_tag) begin
                cmd_hit = 1'b1;
                cmd_way = WAY_BITS'(i);
            end
        end
    end

    assign bus.contains_address         = data_hit;
    assign bus.contains_command_address = cmd_hit;
    assign bus.read_value   = data_hit ? word_of(data_q[data_way], data_word) : '0;
    assign bus.read_command = cmd_hit ? word_of(data_q[cmd_way], cmd_word) : '0;

    logic access_hit, write_hit;
    assign access_hit = (bus.read_trigger || bus.write_trigger) && data_hit;
    assign write_hit  = bus.write_trigger && data_hit;

    // Victim: first invalid way, else oldest way with the lowest index on ties.
    logic [WAY_BITS-1:0] victim;
    logic                found_invalid;
    logic [AGE_BITS-1:0] best_age;

    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        best_age      = age_q[0];
        for (int i = 0; i < WAYS; i++) begin
            if (!valid_q[i] && !found_invalid) begin
                victim        = WAY_BITS'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 1; i < WAYS; i++) begin
                if (age_q[i] > best_age) begin
                    best_age = age_q[i];
                    victim   = WAY_BITS'(i);
                end
            end
        end
    end

    logic                miss;
    logic                invalidate, install, flush_clean;
    logic [WAY_BITS-1:0] ptr_way;
    assign miss    = (state_q == StIdle) && (bus.read_trigger || bus.write_trigger) && !data_hit;
    assign ptr_way = ptr_q[WAY_BITS-1:0];

    always_comb begin
        state_d            = state_q;
        victim_d           = victim_q;
        ptr_d              = ptr_q;
        save_address_d     = save_address_q;
        save_data_d        = save_data_q;
        fill_req_address_d = fill_req_address_q;
        flush_done_d       = 1'b0;
        invalidate         = 1'b0;
        install            = 1'b0;
        flush_clean        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    victim_d           = victim;
                    fill_req_address_d = {data_tag, {OFFSET_BITS{1'b0}}};
                    invalidate         = 1'b1;
                    if (valid_q[victim] && dirty_q[victim]) begin
                        save_address_d = {tag_q[victim], {OFFSET_BITS{1'b0}}};
                        save_data_d    = data_q[victim];
                        state_d        = StWb;
                    end else begin
                        state_d = StReq;
                    end
                end else if (bus.flush_trigger) begin
                    ptr_d   = '0;
                    state_d = StFlushScan;
                end
            end
            StWb: begin
                if (bus.save_ready) state_d = StReq;
            end
            StReq: begin
                if (bus.fill_req_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.fill_data_valid) begin
                    install = 1'b1;
                    state_d = StIdle;
                end
            end
            StFlushScan: begin
                if (ptr_q == PTR_DONE) begin
                    flush_done_d = 1'b1;
                    state_d      = StIdle;
                end else if (valid_q[ptr_way] && dirty_q[ptr_way]) begin
                    save_address_d = {tag_q[ptr_way], {OFFSET_BITS{1'b0}}};
                    save_data_d    = data_q[ptr_way];
                    state_d        = StFlushWb;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StFlushWb: begin
                if (bus.save_ready) begin
                    flush_clean = 1'b1;
                    ptr_d       = ptr_q + 1'b1;
                    state_d     = StFlushScan;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        age_d   = age_q;
        if (access_hit) begin
            for (int i = 0; i < WAYS; i++) begin
                if (valid_q[i] && age_q[i] < age_q[data_way]) age_d[i] = age_q[i] + 1'b1;
            end
            age_d[data_way] = '0;
        end
        if (write_hit) dirty_d[data_way] = 1'b1;
        if (invalidate) begin
            valid_d[victim] = 1'b0;
            dirty_d[victim] = 1'b0;
        end
        // A write landing on the way being flushed keeps it dirty.
        if (flush_clean && !(write_hit && data_way == ptr_way)) dirty_d[ptr_way] = 1'b0;
        if (install) begin
            for (int i = 0; i < WAYS; i++) begin
                if (valid_d[i] && victim_q != WAY_BITS'(i) && age_d[i] != AGE_MAX) begin
                    age_d[i] = age_d[i] + 1'b1;
                end
            end
            valid_d[victim_q] = 1'b1;
            dirty_d[victim_q] = 1'b0;
            age_d[victim_q]   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= StIdle;
            valid_q            <= '0;
            dirty_q            <= '0;
            for (int i = 0; i < WAYS; i++) age_q[i] <= '0;
            victim_q           <= '0;
            ptr_q              <= '0;
            save_address_q     <= '0;
            save_data_q        <= '0;
            fill_req_address_q <= '0;
            flush_done_q       <= 1'b0;
        end else begin
            state_q            <= state_d;
            valid_q            <= valid_d;
            dirty_q            <= dirty_d;
            age_q              <= age_d;
            victim_q           <= victim_d;
            ptr_q              <= ptr_d;
            save_address_q     <= save_address_d;
            save_data_q        <= save_data_d;
            fill_req_address_q <= fill_req_address_d;
            flush_done_q       <= flush_done_d;
        end
    end

    // Payload storage needs no reset; valid_q gates every use of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WAYS; i++) begin
            if (install && victim_q == WAY_BITS'(i)) begin
                data_q[i] <= bus.fill_data;
                tag_q[i]  <= fill_req_address_q[ADDRESS_SIZE-1:OFFSET_BITS];
            end else if (write_hit && data_way == WAY_BITS'(i)) begin
                data_q[i] <= merge_word(data_q[i], data_word, bus.mask, bus.write_value);
            end
        end
    end

    assign bus.busy             = (state_q != StIdle);
    assign bus.save_valid       = (state_q == StWb) || (state_q == StFlushWb);
    assign bus.save_address     = save_address_q;
    assign bus.save_data        = save_data_q;
    assign bus.fill_req_valid   = (state_q == StReq);
    assign bus.fill_req_address = fill_req_address_q;
    assign bus.flush_done       = flush_done_q;
endmodule

// File: tb/tb_chunk_storage_pool_n.sv
// Self-checking bench for chunk_storage_pool_n: directed scenarios then randomized
// traffic against a way-level reference model with backing memory.
module tb_chunk_storage_pool_n;
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chunk_storage_pool_n_if #(
        .CHUNK_PART(128), .DATA_SIZE(32), .MASK_SIZE(4), .ADDRESS_SIZE(28)
    ) bus ();

    chunk_storage_pool_n #(
        .WAYS(4), .CHUNK_PART(128), .DATA_SIZE(32), .MASK_SIZE(4), .ADDRESS_SIZE(28)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-way state plus backing memory of chunks.
    bit           m_valid [4];
    bit           m_dirty [4];
    int           m_age   [4];
    logic [27:0]  m_base  [4];
    logic [127:0] m_data  [4];
    logic [127:0] mem [logic [27:0]];

    int wb_stall   = 0;
    int req_stall  = 0;
    int fill_delay = 0;
    bit junk_fill  = 0;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int word_idx(input logic [27:0] a);
        return int'((a >> 4) & 28'h3);
    endfunction

    function automatic logic [27:0] base_of(input logic [27:0] a);
        return a & ~28'hF;
    endfunction

    function automatic int m_lookup(input logic [27:0] a);
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_base[i] == base_of(a)) return i;
        return -1;
    endfunction

    function automatic int m_victim();
        int v = 0;
        for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
        for (int i = 1; i < 4; i++) if (m_age[i] > m_age[v]) v = i;
        return v;
    endfunction

    function automatic void m_touch(input int h);
        int a = m_age[h];
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_age[i] < a) m_age[i]++;
        m_age[h] = 0;
    endfunction

    function automatic void m_fill(input int v, input logic [27:0] b, input logic [127:0] d);
        for (int i = 0; i < 4; i++) if (i != v && m_valid[i] && m_age[i] < 3) m_age[i]++;
        m_valid[v] = 1; m_dirty[v] = 0; m_age[v] = 0; m_base[v] = b; m_data[v] = d;
    endfunction

    function automatic logic [31:0] m_word(input int w, input logic [27:0] a);
        return m_data[w][word_idx(a)*32 +: 32];
    endfunction

    function automatic logic [127:0] mem_get(input logic [27:0] b);
        if (!mem.exists(b)) mem[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mem[b];
    endfunction

    task automatic clear_inputs();
        bus.address = '0; bus.mask = '0; bus.write_trigger = 0; bus.write_value = '0;
        bus.read_trigger = 0; bus.command_address = '0; bus.save_ready = 0;
        bus.fill_req_ready = 0; bus.fill_data_valid = 0; bus.fill_data = '0;
        bus.flush_trigger = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_age[i] = 0; end
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_save_valid", bus.save_valid, 1'b0);
        check("rst_fill_req_valid", bus.fill_req_valid, 1'b0);
        check("rst_flush_done", bus.flush_done, 1'b0);
        check("rst_save_address", bus.save_address, 28'h0);
        check("rst_save_data", bus.save_data, 128'h0);
        check("rst_fill_req_address", bus.fill_req_address, 28'h0);
    endtask

    task automatic probe(input string tag, input logic [27:0] a);
        int          w = m_lookup(a);
        logic        exp_hit = (w >= 0);
        logic [31:0] exp_val = (w >= 0) ? m_word(w, a) : 32'h0;
        bus.command_address = a;
        #1;
        check({tag, "_cmd_hit"}, bus.contains_command_address, exp_hit);
        check({tag, "_cmd_val"}, bus.read_command, exp_val);
    endtask

    task automatic access(input logic [27:0] a, input bit wr, input logic [3:0] m,
                          input logic [31:0] v);
        int           w, vic;
        bit           need_wb;
        logic [27:0]  wb_base;
        logic [127:0] wb_data, fd;
        @(negedge clk);
        bus.address = a; bus.read_trigger = !wr; bus.write_trigger = wr;
        bus.mask = m; bus.write_value = v;
        #1;
        w = m_lookup(a);
        if (w < 0) begin
            check("miss_contains", bus.contains_address, 1'b0);
            check("miss_read_zero", bus.read_value, 32'h0);
            vic = m_victim();
            need_wb = m_valid[vic] && m_dirty[vic];
            wb_base = m_base[vic];
            wb_data = m_data[vic];
            m_valid[vic] = 0;
            m_dirty[vic] = 0;
            @(negedge clk);
            #1;
            check("busy_after_miss", bus.busy, 1'b1);
            if (need_wb) begin
                for (int c = 0; c <= wb_stall; c++) begin
                    check("wb_valid", bus.save_valid, 1'b1);
                    check("wb_address", bus.save_address, wb_base);
                    check("wb_data", bus.save_data, wb_data);
                    check("wb_no_fill_req", bus.fill_req_valid, 1'b0);
                    if (c == wb_stall) bus.save_ready = 1;
                    @(negedge clk);
                    bus.save_ready = 0;
                    #1;
                end
                check("wb_drop", bus.save_valid, 1'b0);
                mem[wb_base] = wb_data;
            end
            for (int c = 0; c <= req_stall; c++) begin
                check("req_valid", bus.fill_req_valid, 1'b1);
                check("req_address", bus.fill_req_address, base_of(a));
                bus.fill_data_valid = junk_fill;
                bus.fill_data = 128'hBAD0_BAD0;
                if (c == req_stall) bus.fill_req_ready = 1;
                @(negedge clk);
                bus.fill_req_ready = 0;
                bus.fill_data_valid = 0;
                #1;
            end
            check("req_drop", bus.fill_req_valid, 1'b0);
            for (int c = 0; c < fill_delay; c++) begin
                @(negedge clk);
                #1;
                check("wait_busy", bus.busy, 1'b1);
            end
            fd = mem_get(base_of(a));
            bus.fill_data = fd;
            bus.fill_data_valid = 1;
            @(negedge clk);
            bus.fill_data_valid = 0;
            #1;
            m_fill(vic, base_of(a), fd);
            check("busy_after_fill", bus.busy, 1'b0);
            w = vic;
        end
        check("hit_contains", bus.contains_address, 1'b1);
        check("hit_read", bus.read_value, m_word(w, a));
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) m_data[w][word_idx(a)*32 + b*8 +: 8] = v[b*8 +: 8];
            end
            m_dirty[w] = 1;
        end
        m_touch(w);
        @(negedge clk);
        bus.read_trigger = 0;
        bus.write_trigger = 0;
    endtask

    task automatic flush_and_check(input string tag);
        logic [27:0]  exp_base[$];
        logic [127:0] exp_data[$];
        int           n_exp = 0;
        int           saves = 0;
        int           done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                exp_base.push_back(m_base[i]);
                exp_data.push_back(m_data[i]);
                n_exp++;
            end
        end
        @(negedge clk);
        bus.flush_trigger = 1;
        @(negedge clk);
        bus.flush_trigger = 0;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (bus.save_valid) begin
                if (exp_base.size() > 0) begin
                    check({tag, "_save_addr"}, bus.save_address, exp_base[0]);
                    check({tag, "_save_data"}, bus.save_data, exp_data[0]);
                    mem[exp_base[0]] = exp_data[0];
                    void'(exp_base.pop_front());
                    void'(exp_data.pop_front());
                end
                bus.save_ready = 1;
                @(negedge clk);
                bus.save_ready = 0;
                #1;
                saves++;
            end else if (bus.flush_done) begin
                done_cnt++;
                @(negedge clk);
                #1;
                check({tag, "_done_one_cycle"}, bus.flush_done, 1'b0);
                check({tag, "_idle_after"}, bus.busy, 1'b0);
                break;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        check({tag, "_save_count"}, saves, n_exp);
        check({tag, "_done_seen"}, done_cnt, 1);
        for (int i = 0; i < 4; i++) m_dirty[i] = 0;
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        do_reset();

        // Cold miss, refill request held across a stalled handshake.
        mem[28'h100] = 128'hDDDD_CCCC_BBBB_AAAA;
        req_stall = 3; fill_delay = 1;
        access(28'h104, 0, 4'h0, 32'h0);
        bus.command_address = 28'h104;
        #1;
        check("tp1_value", bus.read_command, 32'hBBBB_AAAA);

        // Masked write merge; the following flush must write the chunk back.
        access(28'h104, 1, 4'b0011, 32'h1234_5678);
        bus.command_address = 28'h104;
        #1;
        check("tp2_merge", bus.read_command, 32'hBBBB_5678);
        flush_and_check("tp2_flush");

        // LRU ordering: hit on the oldest way makes way 1 the victim.
        do_reset();
        req_stall = 0; fill_delay = 0;
        access(28'h000, 0, 4'h0, 32'h0);
        access(28'h010, 0, 4'h0, 32'h0);
        access(28'h020, 0, 4'h0, 32'h0);
        access(28'h030, 0, 4'h0, 32'h0);
        access(28'h000, 0, 4'h0, 32'h0);
        access(28'h040, 0, 4'h0, 32'h0);
        probe("tp3_evicted_010", 28'h010);
        bus.command_address = 28'h010;
        #1;
        check("tp3_010_gone", bus.contains_command_address, 1'b0);
        bus.command_address = 28'h000;
        #1;
        check("tp3_000_kept", bus.contains_command_address, 1'b1);
        probe("tp3_040", 28'h040);

        // Dirty victim with save_ready held low.
        access(28'h000, 1, 4'hF, 32'hA5A5_0001);
        access(28'h020, 1, 4'hF, 32'hA5A5_0002);
        access(28'h030, 1, 4'hF, 32'hA5A5_0003);
        access(28'h040, 1, 4'hF, 32'hA5A5_0004);
        wb_stall = 5;
        access(28'h050, 0, 4'h0, 32'h0);
        wb_stall = 0;

        // Flush with exactly two dirty ways, then a second flush finds none.
        do_reset();
        access(28'h000, 0, 4'h0, 32'h0);
        access(28'h010, 0, 4'h0, 32'h0);
        access(28'h020, 0, 4'h0, 32'h0);
        access(28'h030, 0, 4'h0, 32'h0);
        access(28'h010, 1, 4'hF, 32'h1111_1111);
        access(28'h030, 1, 4'hC, 32'h3333_3333);
        flush_and_check("tp5_flush");
        flush_and_check("tp5_reflush");

        // Reset while waiting for refill data.
        do_reset();
        access(28'h000, 0, 4'h0, 32'h0);
        @(negedge clk);
        bus.address = 28'h300;
        bus.read_trigger = 1;
        @(negedge clk);
        #1;
        check("tp6_req", bus.fill_req_valid, 1'b1);
        bus.fill_req_ready = 1;
        @(negedge clk);
        bus.fill_req_ready = 0;
        #1;
        check("tp6_in_wait", bus.busy, 1'b1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        bus.read_trigger = 0;
        bus.address = 28'h000;
        #1;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_age[i] = 0; end
        check("tp6_busy", bus.busy, 1'b0);
        check("tp6_fill_req", bus.fill_req_valid, 1'b0);
        check("tp6_data_miss", bus.contains_address, 1'b0);
        probe("tp6_000", 28'h000);
        probe("tp6_300", 28'h300);

        // Randomized traffic over a pool of eight chunks.
        for (int it = 0; it < 120; it++) begin
            logic [27:0] a;
            a = 28'h400 + 28'($urandom_range(0, 7)) * 28'h10 + 28'($urandom_range(0, 15));
            wb_stall   = $urandom_range(0, 3);
            req_stall  = $urandom_range(0, 3);
            fill_delay = $urandom_range(0, 2);
            junk_fill  = ($urandom_range(0, 1) == 1);
            access(a, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom());
            probe("rnd", 28'h400 + 28'($urandom_range(0, 7)) * 28'h10);
            if (it % 25 == 24) flush_and_check("rnd_flush");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
